mp_irq_responder: RTL and testbench

//  Consumer-side end of the IRQ/ACK retry protocol; sits opposite the IRQ retryer.

---
 rtl/mp_irq_responder_pkg.sv | 12 +
 rtl/mp_rise_detect.sv | 23 ++
 rtl/mp_irq_responder.sv | 145 ++++++++++++++
 tb/tb_mp_irq_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_irq_responder_pkg.sv
// Shared types and constants for the IRQ/ACK responder.
package mp_irq_responder_pkg;

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK_HIGH,
        ACK_GAP_ST
    } ack_state_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/mp_rise_detect.sv
// Registered rising-edge detector: evt is a one-cycle pulse, one cycle after
// din is first sampled high. A held-high input produces a single pulse.
module mp_rise_detect (
    input  logic CLK,
    input  logic RESETN,
    input  logic din,
    output logic evt
);

    logic prev;

    // Remember the last sample and flag a 0->1 transition.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            prev <= 1'b0;
            evt  <= 1'b0;
        end else begin
            prev <= din;
            evt  <= din & ~prev;
        end
    end

endmodule

// File: rtl/mp_irq_responder.sv
// Consumer end of the IRQ/ACK retry protocol. Counts IRQ edges as pending
// work, hands it to a service engine, and returns one ACK pulse per serviced
// event. A retry with nothing pending and nothing queued replays one ACK.
// Optional statistics counters: define MP_IRQ_RESPONDER_STAT_EN.
module mp_irq_responder
    import mp_irq_responder_pkg::*;
#(
    parameter  int CMD_FIFO_DEPTH  = 64,
    parameter  int ACK_PULSE_WIDTH = 4,
    parameter  int ACK_GAP         = 2,
    localparam int CW              = $clog2(CMD_FIFO_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              IRQ_IN,
    input  logic              RETRY_IN,
    output logic              SRV_VALID,
    input  logic              SRV_DONE,
    output logic              ACK_OUT,
    output logic [CW-1:0]     PENDING,
    output logic              OVERFLOW,
    output logic [STAT_W-1:0] STAT_RETRY,
    output logic [STAT_W-1:0] STAT_REPLAY
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CMD_FIFO_DEPTH - 1);
    localparam int            TMAX     = (ACK_PULSE_WIDTH > ACK_GAP) ? ACK_PULSE_WIDTH : ACK_GAP;
    localparam int            TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PW_LOAD  = TW'(ACK_PULSE_WIDTH - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(ACK_GAP - 1);

    logic          irq_evt;
    logic          retry_evt;
    logic          done_acc;
    logic          launch;
    logic          replay;
    logic [CW-1:0] pending;
    logic [CW-1:0] credit;
    logic [CW:0]   credit_sum;
    logic [CW-1:0] credit_nxt;
    logic [TW-1:0] cnt;
    ack_state_t    state;

    mp_rise_detect u_irq_rise (
        .CLK    (CLK),
        .RESETN (RESETN),
        .din    (IRQ_IN),
        .evt    (irq_evt)
    );

    mp_rise_detect u_retry_rise (
        .CLK    (CLK),
        .RESETN (RESETN),
        .din    (RETRY_IN),
        .evt    (retry_evt)
    );

    // Service completions only count while work is being presented.
    assign done_acc = SRV_DONE & SRV_VALID;
    // An ACK starts whenever the FSM is idle and owes at least one.
    assign launch   = (state == ACK_IDLE) && (credit != '0);
    // Retry with nothing pending, owed, or in flight means the peer lost an ACK.
    assign replay   = retry_evt && (pending == '0) && (credit == '0) && (state == ACK_IDLE);

    // Net credit change; launch implies credit>=1 so the sum never underflows.
    always_comb begin
        credit_sum = {1'b0, credit} + (CW+1)'(done_acc) + (CW+1)'(replay) - (CW+1)'(launch);
        credit_nxt = (credit_sum > {1'b0, CNT_MAX}) ? CNT_MAX : credit_sum[CW-1:0];
    end

    // Pending work counter with sticky overflow; outputs registered from it.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pending   <= '0;
            OVERFLOW  <= 1'b0;
            SRV_VALID <= 1'b0;
            PENDING   <= '0;
        end else begin
            if (irq_evt && !done_acc) begin
                if (pending == CNT_MAX) OVERFLOW <= 1'b1;
                else                    pending  <= pending + CW'(1);
            end else if (done_acc && !irq_evt && pending != '0) begin
                pending <= pending - CW'(1);
            end
            SRV_VALID <= (pending != '0);
            PENDING   <= pending;
        end
    end

    // ACK credit: owed ACKs not yet launched.
    always_ff @(posedge CLK) begin
        if (!RESETN) credit <= '0;
        else         credit <= credit_nxt;
    end

    // ACK pulse generator; ACK_OUT is registered from the state, so it trails
    // the state by one cycle and is forced low by reset mid-pulse.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= ACK_IDLE;
            cnt     <= '0;
            ACK_OUT <= 1'b0;
        end else begin
            ACK_OUT <= (state == ACK_HIGH);
            case (state)
                ACK_IDLE: begin
                    if (credit != '0) begin
                        state <= ACK_HIGH;
                        cnt   <= PW_LOAD;
                    end
                end
                ACK_HIGH: begin
                    if (cnt == '0) begin
                        state <= ACK_GAP_ST;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                ACK_GAP_ST: begin
                    if (cnt == '0) state <= ACK_IDLE;
                    else           cnt   <= cnt - TW'(1);
                end
                default: state <= ACK_IDLE;
            endcase
        end
    end

`ifdef MP_IRQ_RESPONDER_STAT_EN
    // Free-running, wrapping statistics of retries seen and ACKs replayed.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            STAT_RETRY  <= '0;
            STAT_REPLAY <= '0;
        end else begin
            if (retry_evt) STAT_RETRY  <= STAT_RETRY + STAT_W'(1);
            if (replay)    STAT_REPLAY <= STAT_REPLAY + STAT_W'(1);
        end
    end
`else
    assign STAT_RETRY  = '0;
    assign STAT_REPLAY = '0;
`endif

endmodule

// File: tb/tb_mp_irq_responder.sv
// Directed bench for mp_irq_responder. Stimulus tasks push the expected ACK
// rise cycle into a queue; a negedge monitor measures every ACK pulse and
// compares its start cycle and width against the queue head.
module tb_mp_irq_responder;

    localparam int PW     = 4;
    localparam int GAP    = 2;
    localparam int PERIOD = PW + GAP + 1;
`ifdef MP_IRQ_RESPONDER_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        IRQ_IN = 1'b0;
    logic        RETRY_IN = 1'b0;
    logic        SRV_DONE = 1'b0;
    logic        SRV_VALID;
    logic        ACK_OUT;
    logic [5:0]  PENDING;
    logic        OVERFLOW;
    logic [31:0] STAT_RETRY;
    logic [31:0] STAT_REPLAY;

    mp_irq_responder #(
        .CMD_FIFO_DEPTH  (64),
        .ACK_PULSE_WIDTH (PW),
        .ACK_GAP         (GAP)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .IRQ_IN      (IRQ_IN),
        .RETRY_IN    (RETRY_IN),
        .SRV_VALID   (SRV_VALID),
        .SRV_DONE    (SRV_DONE),
        .ACK_OUT     (ACK_OUT),
        .PENDING     (PENDING),
        .OVERFLOW    (OVERFLOW),
        .STAT_RETRY  (STAT_RETRY),
        .STAT_REPLAY (STAT_REPLAY)
    );

    always #5 CLK = ~CLK;

    // cyc == k after the k-th rising edge
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int last_rise = -100;
    int exp_retry = 0;
    int exp_replay = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // ACK launches at max(credit-visible cycle, previous launch + period).
    task automatic push_ack(input int rise);
        int r;
        r = rise;
        if (r < last_rise + PERIOD) r = last_rise + PERIOD;
        last_rise = r;
        exp_q.push_back(r);
    endtask

    task automatic irq_pulse();
        IRQ_IN = 1'b1;
        tick(1);
        IRQ_IN = 1'b0;
        tick(1);
    endtask

    // Done sampled at edge D -> ACK_OUT high after D+2.
    task automatic done_one();
        push_ack(cyc + 3);
        SRV_DONE = 1'b1;
        tick(1);
        SRV_DONE = 1'b0;
    endtask

    // Retry sampled at edge R -> replay credit after R+1 -> ACK_OUT after R+3.
    task automatic retry(input bit expect_replay);
        exp_retry++;
        if (expect_replay) begin
            exp_replay++;
            push_ack(cyc + 4);
        end
        RETRY_IN = 1'b1;
        tick(1);
        RETRY_IN = 1'b0;
        tick(1);
    endtask

    task automatic check_stats();
        check("stat_retry", STAT_RETRY, STAT_ON ? exp_retry : 0);
        check("stat_replay", STAT_REPLAY, STAT_ON ? exp_replay : 0);
    endtask

    // ACK monitor / scoreboard
    logic mon_prev = 1'b0;
    bit   mon_in = 1'b0;
    int   mon_rise = 0;
    always @(negedge CLK) begin
        if (!RESETN) begin
            mon_prev = 1'b0;
            mon_in   = 1'b0;
        end else begin
            if (ACK_OUT && !mon_prev) begin
                mon_rise = cyc;
                mon_in   = 1'b1;
            end
            if (!ACK_OUT && mon_prev && mon_in) begin
                mon_in = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ack_unexpected: pulse at cycle %0d, none expected", mon_rise);
                end else begin
                    check("ack_rise", mon_rise, exp_q.pop_front());
                    check("ack_width", cyc - mon_rise, PW);
                end
            end
            mon_prev = ACK_OUT;
        end
    end

    initial begin
        // reset state
        tick(3);
        check("rst_srv_valid", SRV_VALID, 0);
        check("rst_ack", ACK_OUT, 0);
        check("rst_pending", PENDING, 0);
        check("rst_overflow", OVERFLOW, 0);
        check_stats();
        RESETN = 1'b1;
        tick(2);

        // single event: SRV_VALID two edges after IRQ sample
        irq_pulse();
        check("lat_valid_early", SRV_VALID, 0);
        tick(1);
        check("c1_valid", SRV_VALID, 1);
        check("c1_pending", PENDING, 1);
        tick(5);
        done_one();
        tick(1);
        check("c1_pending_0", PENDING, 0);
        check("c1_valid_0", SRV_VALID, 0);
        tick(12);

        // lost-ACK replay
        retry(1'b1);
        tick(12);
        check_stats();

        // retry while work pending: no replay
        irq_pulse();
        irq_pulse();
        tick(2);
        check("c3_pending2", PENDING, 2);
        retry(1'b0);
        tick(10);
        done_one();
        done_one();
        tick(2);
        check("c3_pending_0", PENDING, 0);
        tick(20);
        check_stats();

        // burst of 5 events, then 5 back-to-back services
        for (int i = 0; i < 5; i++) begin
            irq_pulse();
            tick(2);
        end
        tick(2);
        check("c2_pending5", PENDING, 5);
        check("c2_valid", SRV_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            push_ack(cyc + 3);
            SRV_DONE = 1'b1;
            tick(1);
        end
        SRV_DONE = 1'b0;
        tick(2);
        check("c2_pending0", PENDING, 0);
        check("c2_valid0", SRV_VALID, 0);
        tick(45);

        // irq_evt and done_acc in the same cycle: pending holds
        irq_pulse();
        tick(3);
        check("c4_pending1", PENDING, 1);
        IRQ_IN = 1'b1;
        tick(1);
        IRQ_IN = 1'b0;
        push_ack(cyc + 3);
        SRV_DONE = 1'b1;
        tick(1);
        SRV_DONE = 1'b0;
        tick(3);
        check("c4_pending_hold", PENDING, 1);
        check("c4_valid_hold", SRV_VALID, 1);
        done_one();
        tick(15);
        check("c4_pending_clr", PENDING, 0);

        // saturation and sticky overflow
        repeat (70) irq_pulse();
        tick(3);
        check("sat_pending", PENDING, 63);
        check("sat_overflow", OVERFLOW, 1);
        done_one();
        tick(1);
        check("sat_pending_dec", PENDING, 62);
        check("sat_overflow_sticky", OVERFLOW, 1);
        tick(1);
        check("rst_mid_ack_high", ACK_OUT, 1);

        // reset during the second ACK_HIGH cycle
        RESETN = 1'b0;
        exp_q.delete();
        tick(1);
        check("mid_rst_ack", ACK_OUT, 0);
        check("mid_rst_pending", PENDING, 0);
        check("mid_rst_valid", SRV_VALID, 0);
        check("mid_rst_overflow", OVERFLOW, 0);
        exp_retry  = 0;
        exp_replay = 0;
        check_stats();
        tick(1);
        RESETN = 1'b1;
        last_rise = -100;
        tick(2);

        // post-reset single event
        irq_pulse();
        tick(1);
        check("c5_valid", SRV_VALID, 1);
        tick(3);
        done_one();
        tick(1);
        check("c5_pending_0", PENDING, 0);
        tick(15);

        check("ack_all_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
